excp_commit_ctrl: RTL and testbench
===================================

# excp_commit_ctrl

Commit-side consumer of per-instruction exception reports. Sits at the commit head and owns the exception-related CSRs: CRMD, PRMD, ESTAT code fields, ERA, BADV, EENTRY, TLBRENTRY and TLBEHI.VPPN. On an excepting commit or ERTN it applies the architectural CSR side effects, flushes the pipeline and performs a redirect handshake with the frontend. While the redirect is outstanding it stalls further commits.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- commit_valid_i  in  1  head instruction commits this cycle (only sampled when commit_ready_o=1)
- commit_pc_i  in  32  PC of the head instruction
- excp_trigger_i  in  1  head instruction raised an exception
- ecode_i  in  6  exception code
- esubcode_i  in  9  exception subcode
- bad_va_i  in  32  faulting virtual address
- va_error_i  in  1  BADV must be written
- tlbrefill_i  in  1  TLB refill exception; use TLBRENTRY and enter DA mode
- tlbehi_update_i  in  1  TLBEHI.VPPN must be written
- ertn_i  in  1  head instruction is ERTN
- csr_we_i  in  1  software CSR write from the head instruction
- csr_waddr_i  in  14  write address
- csr_wdata_i  in  32  write data
- csr_raddr_i  in  14  read address
- csr_rdata_o  out  32  combinational read data; 0 for unowned addresses
- commit_ready_o  out  1  high only in IDLE
- flush_o  out  1  one-cycle pipeline flush pulse
- redirect_valid_o  out  1  redirect request to the frontend
- redirect_pc_o  out  32  redirect target; stable while redirect_valid_o=1
- redirect_ready_i  in  1  frontend accepts the redirect
- plv_o  out  2  CRMD.PLV
- trans_en_o  out  1  CRMD.PG & ~CRMD.DA
- llbit_clr_o  out  1  one-cycle pulse on ERTN

## Operation
- FSM states: IDLE and REDIRECT.
- Accepted event: commit_valid_i=1 in IDLE with excp_trigger_i=1 or ertn_i=1. An event moves the FSM to REDIRECT at the next edge.
- Exception has priority. If excp_trigger_i and ertn_i are both set, the commit is treated as an exception and the ERTN is dropped.
- Exception CSR side effects, all applied at the accepting edge:
  - PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0, CRMD.IE<=0.
  - ERA<=commit_pc_i.
  - ESTAT[21:16]<=ecode_i, ESTAT[30:22]<=esubcode_i.
  - If va_error_i: BADV<=bad_va_i.
  - If tlbehi_update_i: TLBEHI[31:13]<=bad_va_i[31:13].
  - If tlbrefill_i: CRMD.DA<=1, CRMD.PG<=0.
- Exception redirect target: TLBRENTRY if tlbrefill_i, else EENTRY. The value used is the one held before the edge; it is latched into redirect_pc_o.
- ERTN side effects:
  - CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.
  - If ESTAT.Ecode==6'h3F: CRMD.DA<=0, CRMD.PG<=1.
  - Target is ERA. llbit_clr_o pulses in the first REDIRECT cycle.
- REDIRECT state: redirect_valid_o=1. flush_o=1 in the first REDIRECT cycle only. Leave for IDLE on the first cycle with redirect_ready_i=1.
- Software writes:
  - Honoured only in IDLE when no event is accepted in the same cycle; an excepting instruction never writes.
  - Writable fields: CRMD[8:0], PRMD[2:0], ESTAT[1:0], ERA[31:0], BADV[31:0], EENTRY[31:6], TLBRENTRY[31:6], TLBEHI[31:13]. All other bits read 0.
  - A write with ertn_i=1 and no exception is dropped (the event wins).
- CSR addresses: CRMD 0x0, PRMD 0x1, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, TLBEHI 0x11, TLBRENTRY 0x88.

## Timing
- Reset values: CRMD=32'h8 (DA=1); all other owned CSRs 0; FSM in IDLE.
- Outputs at reset: commit_ready_o=1; flush_o, redirect_valid_o, llbit_clr_o=0; redirect_pc_o=0; plv_o=0; trans_en_o=0.
- CSR updates appear on csr_rdata_o, plv_o and trans_en_o in the cycle after the accepting edge.
- flush_o and redirect_valid_o rise one cycle after acceptance. With redirect_ready_i held high, commit_ready_o is back at 1 two cycles after acceptance.
- commit_valid_i, csr_we_i and event inputs are ignored in REDIRECT.
- Reset asserted mid-REDIRECT: all outputs drop immediately; no partial handshake resumes.
- No back-to-back events: a minimum of one IDLE cycle separates two redirects.

## Structure
- Shared package holds: CSR address constants, the ECODE_TLBR=6'h3F constant, packed field typedefs csr_crmd_t/csr_prmd_t, and the state enum.
- Sub-module excp_csr_regs: register storage, write masking and read mux. The top module holds the FSM, event decode and redirect datapath.

## Test plan
- Reset: CRMD reads 32'h8, trans_en_o=0, commit_ready_o=1, all pulses low.
- ADEF exception: CRMD.PLV=3, IE=1; event at pc=0x1c000100, ecode=0x8, va_error=1, bad_va=0x1c000101, EENTRY=0x1c008000. Required: ERA=0x1c000100, BADV=0x1c000101, PRMD=0x7, PLV=0, a single flush_o pulse, redirect_pc_o=0x1c008000 held until ready.
- TLB refill then ERTN: refill with bad_va=0x00402abc, TLBRENTRY=0x1c00f000. Required: TLBEHI=0x00402000, DA=1, PG=0, target 0x1c00f000. A following ERTN restores PG=1, DA=0, PLV=PPLV, redirects to ERA and pulses llbit_clr_o once.
- Backpressure: redirect_ready_i held low 5 cycles. Required: redirect_valid_o and pc stable, commit_ready_o=0, and a csr_we_i attempted meanwhile has no effect.
- Same-cycle conflict: excp_trigger_i=1 with csr_we_i to ERA=0xdead0000 and ertn_i=1. Required: ERA=commit_pc_i, exception target used, no llbit_clr_o.
- Async reset asserted during REDIRECT. Required: redirect_valid_o=0 immediately, CRMD=32'h8, and a fresh event after reset is handled normally.

Source files
------------

// File: rtl/excp_commit_ctrl_pkg.sv
// ============================================================================
// excp_commit_ctrl_pkg : CSR addresses, field layouts and FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package excp_commit_ctrl_pkg;

    localparam logic [13:0] CSR_CRMD      = 14'h0000;
    localparam logic [13:0] CSR_PRMD      = 14'h0001;
    localparam logic [13:0] CSR_ESTAT     = 14'h0005;
    localparam logic [13:0] CSR_ERA       = 14'h0006;
    localparam logic [13:0] CSR_BADV      = 14'h0007;
    localparam logic [13:0] CSR_EENTRY    = 14'h000C;
    localparam logic [13:0] CSR_TLBEHI    = 14'h0011;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h0088;

    localparam logic [5:0]  ECODE_TLBR    = 6'h3F;

    typedef struct packed {
        logic [1:0] datm;
        logic [1:0] datf;
        logic       pg;
        logic       da;
        logic       ie;
        logic [1:0] plv;
    } csr_crmd_t;

    typedef struct packed {
        logic       pie;
        logic [1:0] pplv;
    } csr_prmd_t;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE     = 1'b0;
    localparam state_t ST_REDIRECT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/excp_commit_ctrl_csr_regs.sv
// ============================================================================
// excp_csr_regs : exception CSR storage, write masking and read mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module excp_csr_regs
    import excp_commit_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        excp_we_i,
    input  logic        ertn_we_i,
    input  logic        sw_we_i,
    input  logic [13:0] sw_waddr_i,
    input  logic [31:0] sw_wdata_i,
    input  logic [31:0] pc_i,
    input  logic [5:0]  ecode_i,
    input  logic [8:0]  esubcode_i,
    input  logic [31:0] bad_va_i,
    input  logic        va_error_i,
    input  logic        tlbrefill_i,
    input  logic        tlbehi_update_i,
    input  logic [13:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  plv_o,
    output logic        trans_en_o,
    output logic [31:0] era_o,
    output logic [31:0] eentry_o,
    output logic [31:0] tlbrentry_o
);

    csr_crmd_t   crmd_q,   crmd_d;
    csr_prmd_t   prmd_q,   prmd_d;
    logic [1:0]  estat_is_q,    estat_is_d;
    logic [5:0]  estat_ecode_q, estat_ecode_d;
    logic [8:0]  estat_esub_q,  estat_esub_d;
    logic [31:0] era_q,    era_d;
    logic [31:0] badv_q,   badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [25:0] tlbrentry_q, tlbrentry_d;
    logic [18:0] tlbehi_vppn_q, tlbehi_vppn_d;

    always_comb begin
        crmd_d        = crmd_q;
        prmd_d        = prmd_q;
        estat_is_d    = estat_is_q;
        estat_ecode_d = estat_ecode_q;
        estat_esub_d  = estat_esub_q;
        era_d         = era_q;
        badv_d        = badv_q;
        eentry_d      = eentry_q;
        tlbrentry_d   = tlbrentry_q;
        tlbehi_vppn_d = tlbehi_vppn_q;
        if (excp_we_i) begin
            prmd_d.pplv   = crmd_q.plv;
            prmd_d.pie    = crmd_q.ie;
            crmd_d.plv    = 2'b00;
            crmd_d.ie     = 1'b0;
            era_d         = pc_i;
            estat_ecode_d = ecode_i;
            estat_esub_d  = esubcode_i;
            if (va_error_i)      badv_d        = bad_va_i;
            if (tlbehi_update_i) tlbehi_vppn_d = bad_va_i[31:13];
            if (tlbrefill_i) begin
                crmd_d.da = 1'b1;
                crmd_d.pg = 1'b0;
            end
        end else if (ertn_we_i) begin
            crmd_d.plv = prmd_q.pplv;
            crmd_d.ie  = prmd_q.pie;
            // Returning from a TLB refill handler leaves direct-address mode.
            if (estat_ecode_q == ECODE_TLBR) begin
                crmd_d.da = 1'b0;
                crmd_d.pg = 1'b1;
            end
        end else if (sw_we_i) begin
            case (sw_waddr_i)
                CSR_CRMD:      crmd_d        = csr_crmd_t'(sw_wdata_i[8:0]);
                CSR_PRMD:      prmd_d        = csr_prmd_t'(sw_wdata_i[2:0]);
                CSR_ESTAT:     estat_is_d    = sw_wdata_i[1:0];
                CSR_ERA:       era_d         = sw_wdata_i;
                CSR_BADV:      badv_d        = sw_wdata_i;
                CSR_EENTRY:    eentry_d      = sw_wdata_i[31:6];
                CSR_TLBEHI:    tlbehi_vppn_d = sw_wdata_i[31:13];
                CSR_TLBRENTRY: tlbrentry_d   = sw_wdata_i[31:6];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crmd_q        <= csr_crmd_t'(9'h008);
            prmd_q        <= '0;
            estat_is_q    <= '0;
            estat_ecode_q <= '0;
            estat_esub_q  <= '0;
            era_q         <= '0;
            badv_q        <= '0;
            eentry_q      <= '0;
            tlbrentry_q   <= '0;
            tlbehi_vppn_q <= '0;
        end else begin
            crmd_q        <= crmd_d;
            prmd_q        <= prmd_d;
            estat_is_q    <= estat_is_d;
            estat_ecode_q <= estat_ecode_d;
            estat_esub_q  <= estat_esub_d;
            era_q         <= era_d;
            badv_q        <= badv_d;
            eentry_q      <= eentry_d;
            tlbrentry_q   <= tlbrentry_d;
            tlbehi_vppn_q <= tlbehi_vppn_d;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            CSR_CRMD:      rdata_o = {23'h0, crmd_q};
            CSR_PRMD:      rdata_o = {29'h0, prmd_q};
            CSR_ESTAT:     rdata_o = {1'b0, estat_esub_q, estat_ecode_q, 14'h0, estat_is_q};
            CSR_ERA:       rdata_o = era_q;
            CSR_BADV:      rdata_o = badv_q;
            CSR_EENTRY:    rdata_o = {eentry_q, 6'h0};
            CSR_TLBEHI:    rdata_o = {tlbehi_vppn_q, 13'h0};
            CSR_TLBRENTRY: rdata_o = {tlbrentry_q, 6'h0};
            default:       rdata_o = 32'h0;
        endcase
    end

    assign plv_o       = crmd_q.plv;
    assign trans_en_o  = crmd_q.pg & ~crmd_q.da;
    assign era_o       = era_q;
    assign eentry_o    = {eentry_q, 6'h0};
    assign tlbrentry_o = {tlbrentry_q, 6'h0};

endmodule

`default_nettype wire

// File: rtl/excp_commit_ctrl.sv
// ============================================================================
// excp_commit_ctrl : commit-head exception/ERTN handling and frontend redirect
// Revision: 1.0
// ============================================================================
`default_nettype none

module excp_commit_ctrl
    import excp_commit_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_pc_i,
    input  logic        excp_trigger_i,
    input  logic [5:0]  ecode_i,
    input  logic [8:0]  esubcode_i,
    input  logic [31:0] bad_va_i,
    input  logic        va_error_i,
    input  logic        tlbrefill_i,
    input  logic        tlbehi_update_i,
    input  logic        ertn_i,
    input  logic        csr_we_i,
    input  logic [13:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [13:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    output logic        commit_ready_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic [1:0]  plv_o,
    output logic        trans_en_o,
    output logic        llbit_clr_o
);

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic        llbit_q, llbit_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        w_accept;
    logic        w_excp;
    logic        w_ertn;
    logic        w_sw_we;
    logic [31:0] w_era;
    logic [31:0] w_eentry;
    logic [31:0] w_tlbrentry;

    // Exception outranks ERTN; any event suppresses the head's own CSR write.
    assign w_accept = (state_q == ST_IDLE) & commit_valid_i;
    assign w_excp   = w_accept & excp_trigger_i;
    assign w_ertn   = w_accept & ertn_i & ~excp_trigger_i;
    assign w_sw_we  = w_accept & csr_we_i & ~excp_trigger_i & ~ertn_i;

    excp_csr_regs u_csr_regs (
        .clk             (clk),
        .rst_n           (rst_n),
        .excp_we_i       (w_excp),
        .ertn_we_i       (w_ertn),
        .sw_we_i         (w_sw_we),
        .sw_waddr_i      (csr_waddr_i),
        .sw_wdata_i      (csr_wdata_i),
        .pc_i            (commit_pc_i),
        .ecode_i         (ecode_i),
        .esubcode_i      (esubcode_i),
        .bad_va_i        (bad_va_i),
        .va_error_i      (va_error_i),
        .tlbrefill_i     (tlbrefill_i),
        .tlbehi_update_i (tlbehi_update_i),
        .raddr_i         (csr_raddr_i),
        .rdata_o         (csr_rdata_o),
        .plv_o           (plv_o),
        .trans_en_o      (trans_en_o),
        .era_o           (w_era),
        .eentry_o        (w_eentry),
        .tlbrentry_o     (w_tlbrentry)
    );

    always_comb begin
        state_d       = state_q;
        flush_d       = w_excp | w_ertn;
        llbit_d       = w_ertn;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (w_excp | w_ertn) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Targets are the pre-edge CSR values, captured alongside the CSR update.
        if (w_excp) begin
            redirect_pc_d = tlbrefill_i ? w_tlbrentry : w_eentry;
        end else if (w_ertn) begin
            redirect_pc_d = w_era;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            flush_q       <= 1'b0;
            llbit_q       <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            llbit_q       <= llbit_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign commit_ready_o   = (state_q == ST_IDLE);
    assign redirect_valid_o = (state_q == ST_REDIRECT);
    assign flush_o          = flush_q;
    assign llbit_clr_o      = llbit_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_excp_commit_ctrl.sv
// ============================================================================
// tb_excp_commit_ctrl : directed scenarios plus random traffic against a CSR-map model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_excp_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid_i = 1'b0;
    logic [31:0] commit_pc_i = '0;
    logic        excp_trigger_i = 1'b0;
    logic [5:0]  ecode_i = '0;
    logic [8:0]  esubcode_i = '0;
    logic [31:0] bad_va_i = '0;
    logic        va_error_i = 1'b0;
    logic        tlbrefill_i = 1'b0;
    logic        tlbehi_update_i = 1'b0;
    logic        ertn_i = 1'b0;
    logic        csr_we_i = 1'b0;
    logic [13:0] csr_waddr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [13:0] csr_raddr_i = '0;
    logic        redirect_ready_i = 1'b0;
    logic [31:0] csr_rdata_o;
    logic        commit_ready_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [1:0]  plv_o;
    logic        trans_en_o;
    logic        llbit_clr_o;

    always #5 clk = ~clk;

    excp_commit_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .commit_valid_i   (commit_valid_i),
        .commit_pc_i      (commit_pc_i),
        .excp_trigger_i   (excp_trigger_i),
        .ecode_i          (ecode_i),
        .esubcode_i       (esubcode_i),
        .bad_va_i         (bad_va_i),
        .va_error_i       (va_error_i),
        .tlbrefill_i      (tlbrefill_i),
        .tlbehi_update_i  (tlbehi_update_i),
        .ertn_i           (ertn_i),
        .csr_we_i         (csr_we_i),
        .csr_waddr_i      (csr_waddr_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_raddr_i      (csr_raddr_i),
        .csr_rdata_o      (csr_rdata_o),
        .commit_ready_o   (commit_ready_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .plv_o            (plv_o),
        .trans_en_o       (trans_en_o),
        .llbit_clr_o      (llbit_clr_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: CSRs as a flat table 0 CRMD,1 PRMD,2 ESTAT,3 ERA,4 BADV,5 EENTRY,6 TLBEHI,7 TLBRENTRY
    logic [31:0] m_csr [8];
    logic [31:0] nc [8];
    logic [31:0] m_tgt;
    bit          m_redir, m_first, m_ertn;
    logic [13:0] addrs [8] = '{14'h0, 14'h1, 14'h5, 14'h6, 14'h7, 14'hC, 14'h11, 14'h88};

    function automatic int csr_idx(input logic [13:0] a);
        for (int i = 0; i < 8; i++) if (addrs[i] == a) return i;
        return -1;
    endfunction

    function automatic logic [31:0] sw_mask(input int i);
        case (i)
            0: return 32'h0000_01ff;
            1: return 32'h0000_0007;
            2: return 32'h0000_0003;
            3, 4: return 32'hffff_ffff;
            5, 7: return 32'hffff_ffc0;
            6: return 32'hffff_e000;
            default: return 32'h0;
        endcase
    endfunction

    int wi;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_csr[i] <= (i == 0) ? 32'h8 : 32'h0;
            m_redir <= 0; m_first <= 0; m_ertn <= 0; m_tgt <= 32'h0;
        end else if (m_redir) begin
            m_first <= 0;
            m_ertn  <= 0;
            if (redirect_ready_i) m_redir <= 0;
        end else begin
            nc = m_csr;
            if (commit_valid_i && excp_trigger_i) begin
                nc[1] = {29'h0, m_csr[0][2:0]};
                nc[0][2:0] = 3'b000;
                nc[3] = commit_pc_i;
                nc[2][30:16] = {esubcode_i, ecode_i};
                if (va_error_i) nc[4] = bad_va_i;
                if (tlbehi_update_i) nc[6] = bad_va_i & 32'hffff_e000;
                if (tlbrefill_i) nc[0][4:3] = 2'b01;
                m_tgt <= tlbrefill_i ? m_csr[7] : m_csr[5];
                m_redir <= 1; m_first <= 1; m_ertn <= 0;
            end else if (commit_valid_i && ertn_i) begin
                nc[0][2:0] = m_csr[1][2:0];
                if (m_csr[2][21:16] == 6'h3f) nc[0][4:3] = 2'b10;
                m_tgt <= m_csr[3];
                m_redir <= 1; m_first <= 1; m_ertn <= 1;
            end else if (commit_valid_i && csr_we_i) begin
                wi = csr_idx(csr_waddr_i);
                if (wi >= 0) nc[wi] = (m_csr[wi] & ~sw_mask(wi)) | (csr_wdata_i & sw_mask(wi));
            end
            m_csr <= nc;
        end
    end

    int ri;
    always @(negedge clk) begin
        ri = csr_idx(csr_raddr_i);
        chk("commit_ready", {31'h0, commit_ready_o}, {31'h0, !m_redir});
        chk("redirect_valid", {31'h0, redirect_valid_o}, {31'h0, m_redir});
        chk("flush", {31'h0, flush_o}, {31'h0, m_redir && m_first});
        chk("llbit_clr", {31'h0, llbit_clr_o}, {31'h0, m_redir && m_first && m_ertn});
        chk("redirect_pc", redirect_pc_o, m_tgt);
        chk("plv", {30'h0, plv_o}, {30'h0, m_csr[0][1:0]});
        chk("trans_en", {31'h0, trans_en_o}, {31'h0, m_csr[0][4] & ~m_csr[0][3]});
        chk("csr_rdata", csr_rdata_o, (ri >= 0) ? m_csr[ri] : 32'h0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_valid_i = 0; excp_trigger_i = 0; ertn_i = 0; csr_we_i = 0;
        va_error_i = 0; tlbrefill_i = 0; tlbehi_update_i = 0;
    endtask

    task automatic rd_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
        csr_raddr_i = a;
        #1;
        chk(name, csr_rdata_o, exp);
    endtask

    task automatic sw_write(input logic [13:0] a, input logic [31:0] d);
        commit_valid_i = 1; csr_we_i = 1; csr_waddr_i = a; csr_wdata_i = d;
        cyc();
        idle();
    endtask

    task automatic excp_ev(input logic [31:0] pc, input logic [5:0] ec, input logic [31:0] va,
                           input logic vae, input logic refill, input logic ehi);
        commit_valid_i = 1; excp_trigger_i = 1; commit_pc_i = pc; ecode_i = ec;
        esubcode_i = 9'h0; bad_va_i = va; va_error_i = vae; tlbrefill_i = refill;
        tlbehi_update_i = ehi;
        cyc();
        idle();
    endtask

    task automatic ertn_ev();
        commit_valid_i = 1; ertn_i = 1;
        cyc();
        idle();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rd_chk("reset_crmd", 14'h0, 32'h8);
        chk("reset_trans_en", {31'h0, trans_en_o}, 32'h0);
        chk("reset_ready", {31'h0, commit_ready_o}, 32'h1);
        chk("reset_pulses", {29'h0, flush_o, llbit_clr_o, redirect_valid_o}, 32'h0);
        rst_n = 1;
        cyc();

        // ADEF exception from PLV3 with interrupts enabled
        sw_write(14'h0, 32'h7);
        sw_write(14'hC, 32'h1c008000);
        excp_ev(32'h1c000100, 6'h8, 32'h1c000101, 1, 0, 0);
        chk("adef_flush", {31'h0, flush_o}, 32'h1);
        chk("adef_pc", redirect_pc_o, 32'h1c008000);
        chk("adef_plv", {30'h0, plv_o}, 32'h0);
        rd_chk("adef_era", 14'h6, 32'h1c000100);
        rd_chk("adef_badv", 14'h7, 32'h1c000101);
        rd_chk("adef_prmd", 14'h1, 32'h7);
        cyc();
        chk("adef_flush_once", {31'h0, flush_o}, 32'h0);
        chk("adef_pc_held", redirect_pc_o, 32'h1c008000);
        redirect_ready_i = 1;
        cyc();
        redirect_ready_i = 0;
        chk("adef_back_idle", {31'h0, commit_ready_o}, 32'h1);

        // TLB refill, then ERTN back
        sw_write(14'h0, 32'h13);
        sw_write(14'h88, 32'h1c00f000);
        excp_ev(32'h1c000200, 6'h3f, 32'h00402abc, 1, 1, 1);
        chk("tlbr_pc", redirect_pc_o, 32'h1c00f000);
        rd_chk("tlbr_tlbehi", 14'h11, 32'h00402000);
        rd_chk("tlbr_crmd", 14'h0, 32'h8);
        rd_chk("tlbr_prmd", 14'h1, 32'h3);
        redirect_ready_i = 1;
        cyc();
        redirect_ready_i = 0;
        ertn_ev();
        chk("ertn_llbit", {31'h0, llbit_clr_o}, 32'h1);
        chk("ertn_pc", redirect_pc_o, 32'h1c000200);
        rd_chk("ertn_crmd", 14'h0, 32'h13);
        chk("ertn_trans_en", {31'h0, trans_en_o}, 32'h1);
        chk("ertn_plv", {30'h0, plv_o}, 32'h3);
        cyc();
        chk("ertn_llbit_once", {31'h0, llbit_clr_o}, 32'h0);
        redirect_ready_i = 1;
        cyc();
        redirect_ready_i = 0;

        // Backpressure with a CSR write attempted while redirecting
        excp_ev(32'h1c000300, 6'h1, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'h0, redirect_valid_o}, 32'h1);
            chk("bp_ready", {31'h0, commit_ready_o}, 32'h0);
            chk("bp_pc", redirect_pc_o, 32'h1c008000);
            if (i == 2) begin
                commit_valid_i = 1; csr_we_i = 1; csr_waddr_i = 14'h6; csr_wdata_i = 32'h12345678;
            end
            cyc();
            idle();
        end
        redirect_ready_i = 1;
        cyc();
        redirect_ready_i = 0;
        rd_chk("bp_era", 14'h6, 32'h1c000300);

        // Exception + ERTN + CSR write in one commit
        commit_valid_i = 1; excp_trigger_i = 1; ertn_i = 1; csr_we_i = 1;
        csr_waddr_i = 14'h6; csr_wdata_i = 32'hdead0000; commit_pc_i = 32'h1c000400;
        ecode_i = 6'h2; tlbrefill_i = 0;
        cyc();
        idle();
        rd_chk("conf_era", 14'h6, 32'h1c000400);
        chk("conf_pc", redirect_pc_o, 32'h1c008000);
        chk("conf_llbit", {31'h0, llbit_clr_o}, 32'h0);
        redirect_ready_i = 1;
        cyc();
        redirect_ready_i = 0;

        // Asynchronous reset during REDIRECT
        excp_ev(32'h1c000500, 6'h3, 32'h0, 0, 0, 0);
        rst_n = 0;
        #1;
        chk("arst_valid", {31'h0, redirect_valid_o}, 32'h0);
        chk("arst_ready", {31'h0, commit_ready_o}, 32'h1);
        rd_chk("arst_crmd", 14'h0, 32'h8);
        cyc();
        rst_n = 1;
        cyc();
        sw_write(14'hC, 32'h1c008040);
        excp_ev(32'h1c000600, 6'h4, 32'h0, 0, 0, 0);
        chk("arst_new_flush", {31'h0, flush_o}, 32'h1);
        chk("arst_new_pc", redirect_pc_o, 32'h1c008040);
        redirect_ready_i = 1;
        cyc();
        cyc();
        chk("arst_new_idle", {31'h0, commit_ready_o}, 32'h1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            commit_valid_i   = ($urandom_range(0, 3) != 0);
            excp_trigger_i   = ($urandom_range(0, 5) == 0);
            ertn_i           = ($urandom_range(0, 6) == 0);
            csr_we_i         = commit_valid_i && ($urandom_range(0, 2) == 0);
            csr_waddr_i      = ($urandom_range(0, 7) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 7)];
            csr_wdata_i      = $urandom;
            csr_raddr_i      = ($urandom_range(0, 7) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 7)];
            commit_pc_i      = $urandom;
            ecode_i          = ($urandom_range(0, 3) == 0) ? 6'h3f : 6'($urandom);
            esubcode_i       = 9'($urandom);
            bad_va_i         = $urandom;
            va_error_i       = 1'($urandom);
            tlbrefill_i      = 1'($urandom);
            tlbehi_update_i  = 1'($urandom);
            redirect_ready_i = 1'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
